// File: rtl/pe_conv_engine_if.sv
// Stream bundle between the PE depacketizer, the conv engine and the psum/adder path.
// The slave modport is the engine's view; master is the view of whoever drives it.
interface pe_conv_engine_if #(
  parameter int DWIDTH     = 8,
  parameter int NPIX       = 5,
  parameter int NFILT      = 3,
  parameter int PSUM_WIDTH = 18
);
  logic [NFILT*DWIDTH-1:0] filt_data;
  logic                    filt_valid;
  logic                    filt_ready;
  logic [NPIX*DWIDTH-1:0]  pix_data;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [PSUM_WIDTH-1:0]   psum_data;
  logic [1:0]              psum_idx;
  logic                    psum_valid;
  logic                    psum_ready;
  logic                    busy;

  modport slave (
    input  filt_data, filt_valid, pix_data, pix_valid, psum_ready,
    output filt_ready, pix_ready, psum_data, psum_idx, psum_valid, busy
  );

  modport master (
    output filt_data, filt_valid, pix_data, pix_valid, psum_ready,
    input  filt_ready, pix_ready, psum_data, psum_idx, psum_valid, busy
  );
endinterface

// File: rtl/pe_conv_engine.sv
// 3-tap 1-D convolution over a 5-pixel word using one shared multiplier, one MAC per cycle.
// The filter stays resident across pixel words; three psums leave one at a time.
module pe_conv_engine #(
  parameter int DWIDTH     = 8,
  parameter int NPIX       = 5,
  parameter int NFILT      = 3,
  parameter int PSUM_WIDTH = 18
) (
  input  logic               clk,
  input  logic               reset,
  pe_conv_engine_if.slave    bus
);

  typedef enum logic [1:0] {WAIT_FILT, WAIT_PIX, MAC, OUT} state_e;

  state_e                  state_q, state_d;
  logic [NFILT*DWIDTH-1:0] filt_q, filt_d;
  logic [NPIX*DWIDTH-1:0]  pix_q, pix_d;
  logic [PSUM_WIDTH-1:0]   acc_q, acc_d;
  logic [1:0]              tap_cnt_q, tap_cnt_d;
  logic [1:0]              out_idx_q, out_idx_d;
  logic [PSUM_WIDTH-1:0]   psum_data_q, psum_data_d;
  logic [1:0]              psum_idx_q, psum_idx_d;

  logic [DWIDTH-1:0]       f_tap [NFILT];
  logic [DWIDTH-1:0]       p_tap [NPIX];
  logic [2:0]              pix_idx;
  logic [2*DWIDTH-1:0]     prod;
  logic [PSUM_WIDTH-1:0]   mac_sum;

  // Element 0 sits in the most significant byte of each word.
  genvar gi;
  generate
    for (gi = 0; gi < NFILT; gi++) begin : g_filt
      assign f_tap[gi] = filt_q[(NFILT-gi)*DWIDTH-1 -: DWIDTH];
    end
    for (gi = 0; gi < NPIX; gi++) begin : g_pix
      assign p_tap[gi] = pix_q[(NPIX-gi)*DWIDTH-1 -: DWIDTH];
    end
  endgenerate

  assign pix_idx = {1'b0, out_idx_q} + {1'b0, tap_cnt_q};
  assign prod    = f_tap[tap_cnt_q] * p_tap[pix_idx];
  assign mac_sum = acc_q + {{(PSUM_WIDTH-2*DWIDTH){1'b0}}, prod};

  always_comb begin
    state_d     = state_q;
    filt_d      = filt_q;
    pix_d       = pix_q;
    acc_d       = acc_q;
    tap_cnt_d   = tap_cnt_q;
    out_idx_d   = out_idx_q;
    psum_data_d = psum_data_q;
    psum_idx_d  = psum_idx_q;
    case (state_q)
      WAIT_FILT: begin
        if (bus.filt_valid) begin
          filt_d  = bus.filt_data;
          state_d = WAIT_PIX;
        end
      end
      WAIT_PIX: begin
        // A filter arriving with a pixel word applies to that same row.
        if (bus.filt_valid) filt_d = bus.filt_data;
        if (bus.pix_valid) begin
          pix_d     = bus.pix_data;
          acc_d     = '0;
          tap_cnt_d = 2'd0;
          out_idx_d = 2'd0;
          state_d   = MAC;
        end
      end
      MAC: begin
        acc_d     = mac_sum;
        tap_cnt_d = tap_cnt_q + 2'd1;
        if (tap_cnt_q == 2'd2) begin
          psum_data_d = mac_sum;
          psum_idx_d  = out_idx_q;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (bus.psum_ready) begin
          if (out_idx_q != 2'd2) begin
            out_idx_d = out_idx_q + 2'd1;
            acc_d     = '0;
            tap_cnt_d = 2'd0;
            state_d   = MAC;
          end else begin
            state_d = WAIT_PIX;
          end
        end
      end
      default: state_d = WAIT_FILT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_FILT;
      filt_q      <= '0;
      pix_q       <= '0;
      acc_q       <= '0;
      tap_cnt_q   <= 2'd0;
      out_idx_q   <= 2'd0;
      psum_data_q <= '0;
      psum_idx_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      filt_q      <= filt_d;
      pix_q       <= pix_d;
      acc_q       <= acc_d;
      tap_cnt_q   <= tap_cnt_d;
      out_idx_q   <= out_idx_d;
      psum_data_q <= psum_data_d;
      psum_idx_q  <= psum_idx_d;
    end
  end

  // Handshake outputs decode state only, so ready never depends on valid.
  assign bus.filt_ready = (state_q == WAIT_FILT) || (state_q == WAIT_PIX);
  assign bus.pix_ready  = (state_q == WAIT_PIX);
  assign bus.psum_valid = (state_q == OUT);
  assign bus.psum_data  = psum_data_q;
  assign bus.psum_idx   = psum_idx_q;
  assign bus.busy       = (state_q == MAC) || (state_q == OUT);

endmodule
